// File: rtl/mac_job_arbiter.sv
// mac_job_arbiter: round-robin sharing of one MAC among NREQ requesters, with a watchdog abort
module mac_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int LEN_W   = 8,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [RES_W-1:0]      result,
    output logic                  err,
    output logic                  busy,
    output logic                  mac_go,
    output logic [LEN_W-1:0]      mac_len,
    output logic                  mac_abort,
    input  logic                  mac_done,
    input  logic [RES_W-1:0]      mac_result
);
    localparam int IW = $clog2(NREQ);
    localparam logic [TO_W-1:0] WD_PRE = TO_W'(TIMEOUT - 2);
    typedef enum logic [1:0] {IDLE, GO, WAIT, RESP} state_t;
    state_t state;
    logic [IW-1:0] rr_ptr, win, pick, j;
    logic [TO_W-1:0] wd;
    logic [LEN_W-1:0] pick_len;
    always_comb begin
        pick = rr_ptr;
        j = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IW'((int'(rr_ptr) + k) % NREQ);
            pick = req[j] ? j : pick;
        end
    end
    assign pick_len = req_len[int'(pick)*LEN_W +: LEN_W];
    assign busy = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            win       <= '0;
            wd        <= '0;
            gnt       <= '0;
            ack       <= '0;
            result    <= '0;
            err       <= 1'b0;
            mac_go    <= 1'b0;
            mac_len   <= '0;
            mac_abort <= 1'b0;
        end else begin
            mac_go    <= 1'b0;
            mac_abort <= 1'b0;
            ack       <= '0;
            case (state)
                IDLE: if (|req) begin
                    state   <= GO;
                    win     <= pick;
                    gnt     <= NREQ'(1) << pick;
                    mac_len <= pick_len;
                    mac_go  <= |pick_len;
                    result  <= '0;
                    err     <= 1'b0;
                end
                GO: begin
                    state <= (mac_len == '0) ? RESP : WAIT;
                    ack   <= (mac_len == '0) ? gnt : '0;
                    wd    <= '0;
                end
                WAIT: begin
                    wd <= wd + 1'b1;
                    if (mac_abort) begin
                        state  <= RESP;
                        ack    <= gnt;
                        err    <= 1'b1;
                        result <= '0;
                    end else if (mac_done) begin
                        state  <= RESP;
                        ack    <= gnt;
                        result <= mac_result;
                    end else if (wd == WD_PRE) begin
                        mac_abort <= 1'b1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    gnt    <= '0;
                    rr_ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_job_arbiter.sv
// tb_mac_job_arbiter: vector table plus scoreboard of acks against a bench MAC model
module tb_mac_job_arbiter;
    logic        clk = 0, rst = 1;
    logic [3:0]  req = 0;
    logic [31:0] req_len = 0;
    logic [3:0]  gnt, ack;
    logic [15:0] result;
    logic        err, busy, mac_go, mac_abort;
    logic [7:0]  mac_len;
    logic        mac_done = 0;
    logic [15:0] mac_result = 0;
    int          cyc = 0, n_vec = 0, n_bad = 0;
    int          done_at = -1, spur_at = -1, mac_delay = -1;
    logic [15:0] mac_res_v = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] lens;
        int          delay;
        logic [15:0] res;
        int          spur;
        logic [3:0]  exp_gnt;
        int          exp_go;
        logic [7:0]  exp_len;
        logic [15:0] exp_res;
        logic        exp_err;
        int          exp_lat;
        int          exp_abort;
    } vec_t;
    typedef struct {
        logic [3:0]  ack;
        logic [15:0] res;
        logic        err;
        int          cyc;
    } exp_t;
    vec_t tbl[10];
    exp_t sb[$];
    exp_t e;

    mac_job_arbiter #(.NREQ(4), .LEN_W(8), .RES_W(16), .TIMEOUT(1024), .TO_W(11)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .gnt(gnt), .ack(ack),
        .result(result), .err(err), .busy(busy), .mac_go(mac_go), .mac_len(mac_len),
        .mac_abort(mac_abort), .mac_done(mac_done), .mac_result(mac_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mac_go) done_at <= (mac_delay < 0) ? -1 : cyc + mac_delay;
        mac_done   <= (cyc == done_at) || (cyc == spur_at);
        mac_result <= mac_res_v;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ack != 0) begin
            if (sb.size() == 0) chk("ack_unexpected", 32'(ack), 0);
            else begin
                e = sb.pop_front();
                chk("ack", 32'(ack), 32'(e.ack));
                chk("result", 32'(result), 32'(e.res));
                chk("err", 32'(err), 32'(e.err));
                chk("ack_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int t0, n, gos, ab;
        @(negedge clk);
        req = v.req;
        req_len = v.lens;
        mac_delay = v.delay;
        mac_res_v = v.res;
        t0 = cyc;
        spur_at = (v.spur < 0) ? -1 : t0 + v.spur;
        sb.push_back('{ack: v.exp_gnt, res: v.exp_res, err: v.exp_err, cyc: t0 + v.exp_lat});
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(v.exp_gnt));
        chk("mac_go", 32'(mac_go), v.exp_go);
        chk("mac_len", 32'(mac_len), 32'(v.exp_len));
        n = 1;
        gos = int'(mac_go);
        ab = 0;
        while (ack == 0 && n < 1200) begin
            @(negedge clk);
            n++;
            gos += int'(mac_go);
            if (mac_abort) ab = n;
        end
        if (ack == 0) chk("ack_seen", 0, 1);
        req = 0;
        chk("mac_go_count", gos, v.exp_go);
        chk("abort_cycle", ab, v.exp_abort);
        @(negedge clk);
        chk("busy_after", 32'(busy), 0);
        chk("gnt_after", 32'(gnt), 0);
    endtask

    initial begin
        int t0, acks;
        tbl[0] = '{4'b0001, 32'h00000005, 8,    16'h0123, -1, 4'b0001, 1, 8'd5,   16'h0123, 1'b0, 10,   0};
        tbl[1] = '{4'b0100, 32'h00000000, 0,    16'h0000, -1, 4'b0100, 0, 8'd0,   16'h0000, 1'b0, 2,    0};
        tbl[2] = '{4'b1001, 32'h07000002, 3,    16'hBEEF, -1, 4'b1000, 1, 8'd7,   16'hBEEF, 1'b0, 5,    0};
        tbl[3] = '{4'b0110, 32'h00040100, 1,    16'h0042, -1, 4'b0010, 1, 8'd1,   16'h0042, 1'b0, 3,    0};
        tbl[4] = '{4'b0011, 32'h00000609, 2,    16'h7777, -1, 4'b0001, 1, 8'd9,   16'h7777, 1'b0, 4,    0};
        tbl[5] = '{4'b1111, 32'h1020FF30, 5,    16'hFFFF, -1, 4'b0010, 1, 8'hFF,  16'hFFFF, 1'b0, 7,    0};
        tbl[6] = '{4'b0010, 32'h00000300, -1,   16'hDEAD, -1, 4'b0010, 1, 8'd3,   16'h0000, 1'b1, 1026, 1025};
        tbl[7] = '{4'b0100, 32'h00040000, 1023, 16'h5A5A, 1,  4'b0100, 1, 8'd4,   16'h5A5A, 1'b0, 1025, 0};
        tbl[8] = '{4'b1001, 32'h03000002, 2,    16'h1111, -1, 4'b0001, 1, 8'd2,   16'h1111, 1'b0, 4,    0};
        tbl[9] = '{4'b1000, 32'h00000000, 0,    16'h0000, -1, 4'b1000, 0, 8'd0,   16'h0000, 1'b0, 2,    0};
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mac_go", 32'(mac_go), 0);
        chk("rst_mac_len", 32'(mac_len), 0);
        chk("rst_mac_abort", 32'(mac_abort), 0);
        rst = 0;
        for (int i = 0; i < 7; i++) run_vec(tbl[i]);
        @(negedge clk);
        spur_at = cyc + 1;
        repeat (2) @(negedge clk);
        chk("idle_done_busy", 32'(busy), 0);
        chk("idle_done_gnt", 32'(gnt), 0);
        run_vec(tbl[7]);
        @(negedge clk);
        req = 4'b0010;
        req_len = 32'h00000300;
        mac_delay = -1;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_gnt", 32'(gnt), 32'(4'b0010));
        rst = 1;
        req = 0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_mac_len", 32'(mac_len), 0);
        chk("mid_rst_abort", 32'(mac_abort), 0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        for (int i = 8; i < 10; i++) run_vec(tbl[i]);
        @(negedge clk);
        req_len = 0;
        req = 4'b1111;
        t0 = cyc;
        for (int k = 0; k < 5; k++)
            sb.push_back('{ack: 4'(1 << (k % 4)), res: 16'h0, err: 1'b0, cyc: t0 + 3 * k + 2});
        acks = 0;
        for (int n = 0; n < 40 && acks < 5; n++) begin
            @(negedge clk);
            if (ack != 0) begin
                acks++;
                req = (acks == 5) ? 4'b0000 : req & ~ack;
            end else if (acks < 5) req = 4'b1111;
        end
        req = 0;
        chk("rr_acks", acks, 5);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
